// File: rtl/param_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : param_loader_pkg
// Description : Shared parameter-memory types, sizes and loader FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package param_loader_pkg;

  localparam int CIM_PARAMS_BANK_SIZE_NUM_WORD = 15872;
  localparam int CIM_PARAMS_NUM_BANKS          = 2;

  typedef logic [14:0] Param_t;
  typedef logic [14:0] ParamAddr_t;
  typedef logic [13:0] ParamBankAddr_t;

  typedef enum logic [1:0] {
    PL_IDLE   = 2'd0,
    PL_LOAD   = 2'd1,
    PL_FINISH = 2'd2
  } ParamLoaderState_t;

  // The 16-bit sum keeps base + count from wrapping before the compare.
  function automatic logic range_exceeds(input ParamAddr_t base,
                                         input ParamAddr_t count,
                                         input int         limit);
    logic [15:0] sum;
    sum = {1'b0, base} + {1'b0, count};
    return sum > 16'(limit);
  endfunction

endpackage
`default_nettype wire

// File: rtl/param_bank_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : param_bank_addr_gen
// Description : Splits a flat parameter address into bank select + bank
//               address and advances it one word at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module param_bank_addr_gen
  import param_loader_pkg::*;
#(
  parameter int BANK_SIZE = CIM_PARAMS_BANK_SIZE_NUM_WORD
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  ParamAddr_t     load_addr,
  input  logic           incr,
  output logic           bank_sel,
  output ParamBankAddr_t bank_addr
);

  localparam ParamAddr_t     c_bank_size = ParamAddr_t'(BANK_SIZE);
  localparam ParamBankAddr_t c_last_addr = ParamBankAddr_t'(BANK_SIZE - 1);

  logic       w_load_bank;
  ParamAddr_t w_load_off;

  assign w_load_bank = (load_addr >= c_bank_size);
  assign w_load_off  = w_load_bank ? (load_addr - c_bank_size) : load_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_sel  <= 1'b0;
      bank_addr <= '0;
    end else if (load) begin
      bank_sel  <= w_load_bank;
      bank_addr <= ParamBankAddr_t'(w_load_off);
    end else if (incr) begin
      // Top of bank 1 is never passed: the job range check forbids it.
      if (bank_addr == c_last_addr) begin
        bank_sel  <= 1'b1;
        bank_addr <= '0;
      end else begin
        bank_addr <= bank_addr + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/param_loader.sv
`default_nettype none
// ============================================================================
// Module      : param_loader
// Description : Streams host parameter words into the CIM parameter banks,
//               one registered write per accepted word. Optional checksum
//               verification is built when PARAM_LOADER_CHECKSUM_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module param_loader
  import param_loader_pkg::*;
#(
  parameter int BANK_SIZE = CIM_PARAMS_BANK_SIZE_NUM_WORD,
  parameter int NUM_BANKS = CIM_PARAMS_NUM_BANKS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [14:0] base_addr,
  input  logic [14:0] len,
  input  logic [15:0] exp_checksum,
  input  logic        in_valid,
  input  logic [14:0] in_data,
  output logic        in_ready,
  input  logic        mem_busy,
  output logic        mem_wr_en,
  output logic        mem_bank_sel,
  output logic [13:0] mem_bank_addr,
  output logic [14:0] mem_wr_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [14:0] words_written
);

  localparam int c_total_words = NUM_BANKS * BANK_SIZE;

  ParamLoaderState_t r_state;
  ParamAddr_t        r_len;

  logic           w_start;
  logic           w_range_err;
  logic           w_accept;
  logic           w_gen_bank;
  ParamBankAddr_t w_gen_addr;
  logic           w_cs_err;

  assign w_start     = start && (r_state == PL_IDLE);
  assign w_range_err = range_exceeds(base_addr, len, c_total_words);
  assign in_ready    = (r_state == PL_LOAD) && !mem_busy;
  assign w_accept    = in_valid && in_ready;

  param_bank_addr_gen #(
    .BANK_SIZE (BANK_SIZE)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (w_start),
    .load_addr (base_addr),
    .incr      (w_accept),
    .bank_sel  (w_gen_bank),
    .bank_addr (w_gen_addr)
  );

`ifdef PARAM_LOADER_CHECKSUM_EN
  logic [15:0] r_sum;
  logic [15:0] r_exp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum <= '0;
      r_exp <= '0;
    end else if (w_start) begin
      r_sum <= '0;
      r_exp <= exp_checksum;
    end else if (w_accept) begin
      r_sum <= r_sum + {1'b0, in_data};
    end
  end

  assign w_cs_err = (r_sum != r_exp);
`else
  logic w_unused_exp;
  assign w_unused_exp = ^exp_checksum;
  assign w_cs_err     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= PL_IDLE;
      r_len         <= '0;
      mem_wr_en     <= 1'b0;
      mem_bank_sel  <= 1'b0;
      mem_bank_addr <= '0;
      mem_wr_data   <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      words_written <= '0;
    end else begin
      done      <= 1'b0;
      mem_wr_en <= 1'b0;
      case (r_state)
        PL_IDLE: begin
          if (start) begin
            r_len         <= len;
            err           <= w_range_err;
            words_written <= '0;
            if (w_range_err || (len == '0)) begin
              done <= 1'b1;
            end else begin
              r_state <= PL_LOAD;
              busy    <= 1'b1;
            end
          end
        end
        PL_LOAD: begin
          if (w_accept) begin
            mem_wr_en     <= 1'b1;
            mem_bank_sel  <= w_gen_bank;
            mem_bank_addr <= w_gen_addr;
            mem_wr_data   <= in_data;
            words_written <= words_written + 1'b1;
            if ((words_written + 1'b1) == r_len) begin
              r_state <= PL_FINISH;
            end
          end
        end
        PL_FINISH: begin
          // Last write is on the port now; checksum includes it already.
          r_state <= PL_IDLE;
          busy    <= 1'b0;
          done    <= 1'b1;
          if (w_cs_err) begin
            err <= 1'b1;
          end
        end
        default: begin
          r_state <= PL_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_param_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_loader
// Description : Randomized self-checking bench for param_loader against a
//               flat-address reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_param_loader;

  localparam int c_bank = 15872;
  localparam int c_top  = 2 * c_bank;

  logic        clk;
  logic        rst;
  logic        start;
  logic [14:0] base_addr;
  logic [14:0] len;
  logic [15:0] exp_checksum;
  logic        in_valid;
  logic [14:0] in_data;
  logic        in_ready;
  logic        mem_busy;
  logic        mem_wr_en;
  logic        mem_bank_sel;
  logic [13:0] mem_bank_addr;
  logic [14:0] mem_wr_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [14:0] words_written;

  int n_tests = 0;
  int n_fail  = 0;

  param_loader dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .base_addr     (base_addr),
    .len           (len),
    .exp_checksum  (exp_checksum),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .mem_busy      (mem_busy),
    .mem_wr_en     (mem_wr_en),
    .mem_bank_sel  (mem_bank_sel),
    .mem_bank_addr (mem_bank_addr),
    .mem_wr_data   (mem_wr_data),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .words_written (words_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_in_ready"}, in_ready, 0);
    check_eq({tag, "_wr_en"},    mem_wr_en, 0);
    check_eq({tag, "_bank"},     mem_bank_sel, 0);
    check_eq({tag, "_addr"},     mem_bank_addr, 0);
    check_eq({tag, "_data"},     mem_wr_data, 0);
    check_eq({tag, "_busy"},     busy, 0);
    check_eq({tag, "_done"},     done, 0);
    check_eq({tag, "_err"},      err, 0);
    check_eq({tag, "_ww"},       words_written, 0);
  endtask

  // Expected write location from the flat address alone.
  task automatic check_write(input int flat, input logic [14:0] data);
    check_eq("wr_bank", mem_bank_sel, flat / c_bank);
    check_eq("wr_addr", mem_bank_addr, flat % c_bank);
    check_eq("wr_data", mem_wr_data, data);
  endtask

  task automatic run_job(input int b, input int l, input int vpct, input int bpct,
                         input bit bad_cs, input bit max_words);
    logic [14:0] words[$];
    logic [14:0] w;
    logic [15:0] sum;
    bit          reject;
    bit          exp_err;
    bit          pend;
    bit          last;
    int          pend_flat;
    logic [14:0] pend_data;
    int          idx;
    int          cyc;

    sum    = '0;
    reject = (b + l) > c_top;
    for (int i = 0; i < l; i++) begin
      w = max_words ? 15'h7fff : 15'($urandom);
      words.push_back(w);
      sum = sum + {1'b0, w};
    end
`ifdef PARAM_LOADER_CHECKSUM_EN
    exp_err = bad_cs;
`else
    exp_err = 1'b0;
`endif

    @(posedge clk); #1;
    start        = 1'b1;
    base_addr    = 15'(b);
    len          = 15'(l);
    exp_checksum = bad_cs ? (sum ^ 16'h0001) : sum;
    in_valid     = 1'b0;
    mem_busy     = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;

    if (reject || l == 0) begin
      @(negedge clk);
      check_eq("short_done",  done, 1);
      check_eq("short_err",   err, reject);
      check_eq("short_busy",  busy, 0);
      check_eq("short_wr_en", mem_wr_en, 0);
      check_eq("short_ww",    words_written, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("short_done_pulse", done, 0);
      return;
    end

    idx  = 0;
    pend = 1'b0;
    last = 1'b0;
    cyc  = 0;
    pend_flat = 0;
    pend_data = '0;
    while (!last && cyc < 64 * l + 64) begin
      in_valid = ($urandom_range(99) < vpct);
      mem_busy = ($urandom_range(99) < bpct);
      in_data  = words[idx];
      @(negedge clk);
      check_eq("load_busy",  busy, 1);
      check_eq("load_done",  done, 0);
      check_eq("load_err",   err, 0);
      check_eq("in_ready",   in_ready, !mem_busy);
      check_eq("wr_en",      mem_wr_en, pend);
      if (pend) check_write(pend_flat, pend_data);
      check_eq("load_ww",    words_written, idx);
      pend = in_valid && !mem_busy;
      if (pend) begin
        pend_flat = b + idx;
        pend_data = words[idx];
        idx++;
        last = (idx == l);
      end
      cyc++;
      @(posedge clk); #1;
    end

    if (!last) begin
      check_eq("timeout", 0, 1);
      in_valid = 1'b0;
      rst      = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      return;
    end

    in_valid = 1'b0;
    mem_busy = 1'($urandom_range(1));
    @(negedge clk);
    check_eq("fin_wr_en",    mem_wr_en, 1);
    check_write(pend_flat, pend_data);
    check_eq("fin_busy",     busy, 1);
    check_eq("fin_done",     done, 0);
    check_eq("fin_in_ready", in_ready, 0);
    check_eq("fin_ww",       words_written, l);
    @(posedge clk); #1;
    mem_busy = 1'b0;
    @(negedge clk);
    check_eq("end_done",  done, 1);
    check_eq("end_busy",  busy, 0);
    check_eq("end_err",   err, exp_err);
    check_eq("end_wr_en", mem_wr_en, 0);
    check_eq("end_ww",    words_written, l);
  endtask

  initial begin
    int sel;
    int b;
    rst          = 1'b1;
    start        = 1'b0;
    base_addr    = '0;
    len          = '0;
    exp_checksum = '0;
    in_valid     = 1'b0;
    in_data      = '0;
    mem_busy     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    run_job(0, 4, 100, 0, 1'b0, 1'b0);
    run_job(15870, 4, 100, 0, 1'b0, 1'b0);
    run_job(200, 6, 100, 40, 1'b0, 1'b0);
    run_job(31000, 800, 100, 0, 1'b0, 1'b0);
    run_job(50, 0, 100, 0, 1'b0, 1'b0);
    run_job(31740, 4, 80, 20, 1'b0, 1'b0);
    run_job(31741, 4, 80, 20, 1'b0, 1'b0);
    run_job(10, 2, 100, 0, 1'b0, 1'b1);
    run_job(10, 2, 100, 0, 1'b1, 1'b1);

    // Reset in the middle of a 10-word job, after 3 words.
    @(posedge clk); #1;
    start = 1'b1; base_addr = 15'd500; len = 15'd10; exp_checksum = '0;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; mem_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = 15'(i + 1);
      @(posedge clk);
      #1;
    end
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    run_job(100, 2, 100, 0, 1'b0, 1'b0);

    for (int j = 0; j < 16; j++) begin
      sel = $urandom_range(2);
      if (sel == 0)      b = $urandom_range(c_top - 1);
      else if (sel == 1) b = c_bank - $urandom_range(1, 12);
      else               b = c_top - $urandom_range(0, 30);
      run_job(b, $urandom_range(0, 24), $urandom_range(40, 100),
              $urandom_range(0, 50), 1'($urandom_range(1)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
